// File: rtl/alu_uart_core_pkg.sv
// Shared definitions for the ALU/UART datapath.
// Holds the opcode values, the control FSM states and the 8N1 frame constants.
package alu_uart_core_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic UART_START     = 1'b0;
  localparam logic UART_STOP      = 1'b1;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
// byte_done fires in the last stop-bit cycle so the next byte can be loaded back-to-back.
module uart_tx_byte
  import alu_uart_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [3:0]        LAST_BIT  = 4'(UART_DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);

  logic              active;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_idx;
  logic [7:0]        data_q;
  logic              bit_end;

  assign bit_end   = active && (baud_cnt == LAST_TICK);
  assign byte_done = ena && bit_end && (bit_idx == LAST_BIT);
  assign busy      = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
    end else if (ena) begin
      if (load) begin
        active   <= 1'b1;
        baud_cnt <= '0;
        bit_idx  <= '0;
        data_q   <= data;
      end else if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == LAST_BIT) active <= 1'b0;
        else                     bit_idx <= bit_idx + 4'd1;
      end else if (active) begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

  // Line is driven purely from registers, so an async reset returns it to idle immediately.
  always_comb begin
    tx = UART_STOP;
    if (active) begin
      if (bit_idx == 4'd0)           tx = UART_START;
      else if (bit_idx != LAST_BIT)  tx = data_q[3'(bit_idx - 4'd1)];
    end
  end

endmodule

// File: rtl/alu_uart_core.sv
// Operand capture, one-cycle ALU execution and byte-wise UART serialisation of the result.
// busy covers the whole transaction; done pulses once after the final stop bit.
module alu_uart_core
  import alu_uart_core_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               carry,
  output logic               result_valid,
  output logic               uart_tx,
  output logic               busy,
  output logic               done
);

  localparam int RW     = 2 * WIDTH;
  localparam int NBYTES = (RW + 7) / 8;

  state_t              state, next_state;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [2:0]          op_q;
  logic [2:0]          byte_idx;
  logic [RW-1:0]       ae, be, alu_res;
  logic                alu_carry;
  logic [NBYTES*8-1:0] padded;
  logic [7:0]          tx_data;
  logic                tx_load, tx_busy, tx_done;

  assign ae   = RW'(a_q);
  assign be   = RW'(b_q);
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = ae + be;
        alu_carry = alu_res[WIDTH];
      end
      OP_SUB: begin
        alu_res   = ae - be;
        alu_carry = (a_q < b_q);
      end
      OP_MUL:  alu_res = ae * be;
      OP_AND:  alu_res = ae & be;
      OP_OR:   alu_res = ae | be;
      OP_XOR:  alu_res = ae ^ be;
      OP_SHL:  alu_res = (int'(b_q) >= RW) ? '0 : (ae << b_q);
      OP_EQ:   alu_res = RW'(a_q == b_q);
      default: alu_res = '0;
    endcase
  end

  // Bytes above RW are zero-padded; byte_idx counts bytes already handed to the transmitter.
  always_comb begin
    padded         = '0;
    padded[RW-1:0] = result;
    tx_data        = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (int'(byte_idx) == k) tx_data = padded[8*k +: 8];
    end
  end

  always_comb begin
    next_state = state;
    tx_load    = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_EXEC;
      ST_EXEC: next_state = ST_SEND;
      ST_SEND: begin
        if (!tx_busy) begin
          tx_load = 1'b1;
        end else if (tx_done) begin
          if (byte_idx == 3'(NBYTES)) next_state = ST_DONE;
          else                        tx_load    = 1'b1;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result       <= '0;
      zero         <= 1'b0;
      carry        <= 1'b0;
      result_valid <= 1'b0;
      byte_idx     <= '0;
    end else if (ena) begin
      state        <= next_state;
      result_valid <= 1'b0;
      if (state == ST_IDLE && start) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= opcode;
      end
      if (state == ST_EXEC) begin
        result       <= alu_res;
        zero         <= (alu_res == '0);
        carry        <= alu_carry;
        result_valid <= 1'b1;
        byte_idx     <= '0;
      end
      if (tx_load) byte_idx <= byte_idx + 3'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .load     (tx_load),
    .data     (tx_data),
    .tx       (uart_tx),
    .busy     (tx_busy),
    .byte_done(tx_done)
  );

endmodule

// File: tb/tb_alu_uart_core.sv
// Randomised bench for alu_uart_core with a 4-bit and an 8-bit instance.
// Expected results and line waveforms come from an arithmetic model of the operations and the 8N1 frame.
module tb_alu_uart_core;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        start4 = 1'b0, start8 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  op4 = '0, op8 = '0;
  logic [7:0]  result4;
  logic [15:0] result8;
  logic        zero4, carry4, rv4, tx4, busy4, done4;
  logic        zero8, carry8, rv8, tx8, busy8, done8;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_uart_core #(.WIDTH(4), .CLKS_PER_BIT(CPB)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start4), .a(a4), .b(b4), .opcode(op4),
    .result(result4), .zero(zero4), .carry(carry4), .result_valid(rv4),
    .uart_tx(tx4), .busy(busy4), .done(done4)
  );

  alu_uart_core #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start8), .a(a8), .b(b8), .opcode(op8),
    .result(result8), .zero(zero8), .carry(carry8), .result_valid(rv8),
    .uart_tx(tx8), .busy(busy8), .done(done8)
  );

  // Reference arithmetic on plain integers, result taken modulo 2^(2w).
  function automatic void model(input int w, input longint av, input longint bv, input int op,
                                output longint res, output bit cy);
    longint m = longint'(1) << (2 * w);
    cy = 1'b0;
    case (op)
      0: begin res = (av + bv) % m; cy = ((av + bv) >= (longint'(1) << w)); end
      1: begin res = (av - bv + m) % m; cy = (av < bv); end
      2: res = (av * bv) % m;
      3: res = av & bv;
      4: res = av | bv;
      5: res = av ^ bv;
      6: res = (bv >= 2 * w) ? 0 : (av * (longint'(1) << bv)) % m;
      default: res = (av == bv) ? 1 : 0;
    endcase
  endfunction

  // One transaction: expected line trace is idle, idle, frames, idle over the busy window.
  task automatic test_transaction(input bit wide, input int av, input int bv, input int op,
                                  input string tag, input int gap, input bit inject);
    int w = wide ? 8 : 4;
    int nb = (2 * w + 7) / 8;
    int f = nb * 10 * CPB;
    longint er, got_res, held;
    bit ec, got_z, got_c, timeout;
    int exp_tx[$];
    int rv_at, done_at, exp_len, j, off, rv_cnt, done_cnt, rv_seen, done_seen, tx_bad;
    bit s_busy, s_tx, s_rv, s_done;
    longint s_res;
    bit s_z, s_c;

    model(w, longint'(av), longint'(bv), op, er, ec);
    exp_tx.push_back(1);
    exp_tx.push_back(1);
    for (int k = 0; k < nb; k++) begin
      for (int bit_i = 0; bit_i < 10; bit_i++) begin
        int v;
        if (bit_i == 0)      v = 0;
        else if (bit_i == 9) v = 1;
        else                 v = int'((er >> (8 * k + bit_i - 1)) & 1);
        for (int c = 0; c < CPB; c++) exp_tx.push_back(v);
      end
    end
    exp_tx.push_back(1);
    rv_at = 1;
    done_at = f + 2;
    if (gap >= 0) begin
      for (int r = 0; r < 7; r++) exp_tx.insert(gap + 1, exp_tx[gap]);
      if (done_at > gap) done_at += 7;
      if (rv_at > gap) rv_at += 7;
    end
    exp_len = exp_tx.size();

    @(negedge clk);
    if (wide) begin a8 = 8'(av); b8 = 8'(bv); op8 = 3'(op); start8 = 1'b1; end
    else      begin a4 = 4'(av); b4 = 4'(bv); op4 = 3'(op); start4 = 1'b1; end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;

    j = 0; off = 0; rv_cnt = 0; done_cnt = 0; rv_seen = -1; done_seen = -1; tx_bad = -1;
    timeout = 1'b1; got_res = -1; got_z = 1'b0; got_c = 1'b0;
    for (int cyc = 0; cyc < exp_len + 20; cyc++) begin
      if (wide) begin
        s_busy = busy8; s_tx = tx8; s_rv = rv8; s_done = done8;
        s_res = longint'(result8); s_z = zero8; s_c = carry8;
      end else begin
        s_busy = busy4; s_tx = tx4; s_rv = rv4; s_done = done4;
        s_res = longint'(result4); s_z = zero4; s_c = carry4;
      end
      if (!s_busy) begin
        timeout = 1'b0;
        break;
      end
      if (tx_bad < 0 && (j >= exp_len || int'(s_tx) != exp_tx[j])) tx_bad = j;
      if (s_rv) begin
        rv_cnt++; rv_seen = j; got_res = s_res; got_z = s_z; got_c = s_c;
      end
      if (s_done) begin
        done_cnt++; done_seen = j;
      end
      if (j == gap) begin
        ena = 1'b0; off = 7;
      end else if (off > 0) begin
        off--;
        if (off == 0) ena = 1'b1;
      end
      if (inject && (j == exp_len / 2 || s_done)) begin
        a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
        if (wide) start8 = 1'b1; else start4 = 1'b1;
      end else begin
        start4 = 1'b0; start8 = 1'b0;
      end
      j++;
      @(negedge clk);
    end
    start4 = 1'b0;
    start8 = 1'b0;
    ena = 1'b1;
    held = wide ? longint'(result8) : longint'(result4);

    n_cmp++;
    if (timeout) begin n_fail++; $display("[TB] FAIL %s timeout: busy still high after %0d cycles", tag, j); end
    n_cmp++;
    if (j !== exp_len) begin n_fail++; $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", tag, j, exp_len); end
    n_cmp++;
    if (tx_bad >= 0) begin n_fail++; $display("[TB] FAIL %s uart_trace: first wrong cycle %0d expected no wrong cycle (-1)", tag, tx_bad); end
    n_cmp++;
    if (rv_cnt !== 1 || rv_seen !== rv_at) begin
      n_fail++; $display("[TB] FAIL %s result_valid: got %0d pulses at %0d expected 1 at %0d", tag, rv_cnt, rv_seen, rv_at);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_seen !== done_at) begin
      n_fail++; $display("[TB] FAIL %s done: got %0d pulses at %0d expected 1 at %0d", tag, done_cnt, done_seen, done_at);
    end
    n_cmp++;
    if (got_res !== er) begin n_fail++; $display("[TB] FAIL %s result: got %0h expected %0h", tag, got_res, er); end
    n_cmp++;
    if (got_z !== (er == 0)) begin n_fail++; $display("[TB] FAIL %s zero: got %0b expected %0b", tag, got_z, (er == 0)); end
    n_cmp++;
    if (got_c !== ec) begin n_fail++; $display("[TB] FAIL %s carry: got %0b expected %0b", tag, got_c, ec); end
    n_cmp++;
    if (held !== er) begin n_fail++; $display("[TB] FAIL %s result_held: got %0h expected %0h", tag, held, er); end
    if (inject) begin
      int extra = 0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if ((wide ? busy8 : busy4) !== 1'b0) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin n_fail++; $display("[TB] FAIL %s start_on_done: busy seen %0d cycles expected 0", tag, extra); end
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({result4, zero4, carry4, rv4, tx4, busy4, done4} !== {8'h00, 6'b000100}) begin
      n_fail++; $display("[TB] FAIL reset4: got %0h expected %0h", {result4, zero4, carry4, rv4, tx4, busy4, done4}, {8'h00, 6'b000100});
    end
    n_cmp++;
    if ({result8, zero8, carry8, rv8, tx8, busy8, done8} !== {16'h0000, 6'b000100}) begin
      n_fail++; $display("[TB] FAIL reset8: got %0h expected %0h", {result8, zero8, carry8, rv8, tx8, busy8, done8}, {16'h0000, 6'b000100});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_carry;
    test_transaction(1'b0, 9, 8, 0, "add_9_8", -1, 1'b0);
  endtask

  task automatic test_mul_wide;
    test_transaction(1'b1, 255, 255, 2, "mul_ff_ff", -1, 1'b0);
  endtask

  task automatic test_sub_xor;
    test_transaction(1'b0, 3, 5, 1, "sub_3_5", -1, 1'b0);
    test_transaction(1'b0, 5, 5, 5, "xor_5_5", -1, 1'b0);
  endtask

  task automatic test_ignored_starts;
    test_transaction(1'b0, 7, 6, 2, "mul_inject", -1, 1'b1);
    test_transaction(1'b1, 200, 100, 0, "add8_inject", -1, 1'b1);
  endtask

  task automatic test_reset_mid_frame;
    int bad = 0;
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd8; op4 = 3'd0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx4 !== 1'b1 || busy4 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_mid_frame: got tx=%0b busy=%0b expected tx=1 busy=0", tx4, busy4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx4 !== 1'b1 || busy4 !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL no_stray_frame: got %0d active cycles expected 0", bad); end
    test_transaction(1'b0, 6, 3, 1, "after_reset", -1, 1'b0);
  endtask

  task automatic test_ena_stretch;
    test_transaction(1'b0, 12, 3, 4, "or_ena_gap", 20, 1'b0);
    test_transaction(1'b1, 0, 77, 3, "and8_ena_gap", 50, 1'b0);
    @(negedge clk);
    ena = 1'b0; start4 = 1'b1;
    @(negedge clk);
    ena = 1'b1; start4 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy4 !== 1'b0) begin n_fail++; $display("[TB] FAIL start_with_ena_low: got busy=%0b expected 0", busy4); end
  endtask

  task automatic test_boundaries;
    test_transaction(1'b0, 5, 8, 6, "shl_b_eq_rw", -1, 1'b0);
    test_transaction(1'b0, 15, 15, 6, "shl_b_max", -1, 1'b0);
    test_transaction(1'b0, 1, 7, 6, "shl_b_7", -1, 1'b0);
    test_transaction(1'b0, 6, 6, 7, "eq_same", -1, 1'b0);
    test_transaction(1'b0, 6, 7, 7, "eq_diff", -1, 1'b0);
    test_transaction(1'b0, 15, 15, 0, "add_max", -1, 1'b0);
    test_transaction(1'b0, 0, 15, 1, "sub_0_15", -1, 1'b0);
    test_transaction(1'b1, 3, 16, 6, "shl8_b_eq_rw", -1, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++)
      test_transaction(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 7)), "rand4", -1, 1'b0);
    for (int i = 0; i < 6; i++)
      test_transaction(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 7)), "rand8", -1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting alu_uart_core bench");
    test_reset;
    test_add_carry;
    test_mul_wide;
    test_sub_xor;
    test_ignored_starts;
    test_reset_mid_frame;
    test_ena_stretch;
    test_boundaries;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
